// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings and reset image for the snake body controller
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_e;

    localparam int         GRID_W_DEF = 40;
    localparam int         GRID_H_DEF = 30;
    localparam logic [5:0] RST_HEAD_X = 6'd20;
    localparam logic [5:0] RST_HEAD_Y = 6'd15;
    localparam int         RST_LEN    = 3;

    // Segments are packed {x, y}; the start-up body trails to the left of the head.
    function automatic logic [11:0] reset_seg(input int idx);
        if (idx < RST_LEN) begin
            return {RST_HEAD_X - 6'(idx), RST_HEAD_Y};
        end
        return 12'd0;
    endfunction

    // Opposite directions differ only in bit 0 of the encoding.
    function automatic logic is_reverse(input dir_e a, input dir_e b);
        return (a ^ b) == 2'b01;
    endfunction

endpackage

// File: rtl/snake_seg_array.sv
// rtl/snake_seg_array.sv - segment shift register with new-head and render-query match vectors
module snake_seg_array
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [11:0]        new_head_i,
    input  logic [5:0]         qx_i,
    input  logic [5:0]         qy_i,
    output logic [11:0]        head_o,
    output logic [MAX_LEN-1:0] new_match_o,
    output logic [MAX_LEN-1:0] q_match_o
);

    logic [11:0] seg_q [MAX_LEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= reset_seg(i);
        end else if (load_i) begin
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= reset_seg(i);
        end else if (shift_i) begin
            seg_q[0] <= new_head_i;
            for (int i = 1; i < MAX_LEN; i++) seg_q[i] <= seg_q[i-1];
        end
    end

    always_comb begin
        new_match_o = '0;
        q_match_o   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            new_match_o[i] = (seg_q[i] == new_head_i);
            q_match_o[i]   = (seg_q[i] == {qx_i, qy_i});
        end
    end

    assign head_o = seg_q[0];

endmodule

// File: rtl/snake_body_ctrl.sv
// rtl/snake_body_ctrl.sv - snake FSM, step timing, steering, growth and collision; SNAKE_WRAP_WALLS_EN wraps walls
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int MOVE_DIV = 5_000_000,
    parameter int MAX_LEN  = 32,
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dirBtn,
    input  logic       addLength,
    input  logic [5:0] qX,
    input  logic [5:0] qY,
    output logic [5:0] headX,
    output logic [5:0] headY,
    output logic [5:0] length,
    output logic       qHit,
    output logic       gameOver,
    output logic       running
);

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    state_e             state_q;
    dir_e               dir_q, next_dir_q, btn_dir, ref_dir;
    logic [CNT_W-1:0]   cnt_q;
    logic [5:0]         len_q;
    logic               grow_pend_q, add_q, q_hit_q;
    logic               btn_valid, tick, add_rise, grow_now;
    logic               wall_hit, self_hit, collide, shift, load;
    logic [11:0]        head_seg;
    logic [5:0]         new_x, new_y;
    logic [MAX_LEN-1:0] new_match, q_match, live_mask, self_mask;

    always_comb begin
        btn_valid = 1'b1;
        btn_dir   = DIR_RIGHT;
        case (dirBtn)
            4'b1000: btn_dir = DIR_UP;
            4'b0100: btn_dir = DIR_DOWN;
            4'b0010: btn_dir = DIR_LEFT;
            4'b0001: btn_dir = DIR_RIGHT;
            default: btn_valid = 1'b0;
        endcase
    end

    assign tick     = (state_q == S_RUN) && (cnt_q == CNT_W'(MOVE_DIV - 1));
    assign add_rise = addLength && !add_q;
    assign grow_now = (grow_pend_q || add_rise) && (int'(len_q) < MAX_LEN);
    // On a step the pending direction becomes current, so reversal is judged against it.
    assign ref_dir  = tick ? next_dir_q : dir_q;

    always_comb begin
        new_x = head_seg[11:6];
        new_y = head_seg[5:0];
        case (next_dir_q)
            DIR_UP:    new_y = head_seg[5:0] - 6'd1;
            DIR_DOWN:  new_y = head_seg[5:0] + 6'd1;
            DIR_LEFT:  new_x = head_seg[11:6] - 6'd1;
            default:   new_x = head_seg[11:6] + 6'd1;
        endcase
`ifdef SNAKE_WRAP_WALLS_EN
        if (new_x == 6'd0)                 new_x = 6'(GRID_W - 2);
        else if (new_x == 6'(GRID_W - 1))  new_x = 6'd1;
        if (new_y == 6'd0)                 new_y = 6'(GRID_H - 2);
        else if (new_y == 6'(GRID_H - 1))  new_y = 6'd1;
        wall_hit = 1'b0;
`else
        wall_hit = (new_x == 6'd0) || (new_x == 6'(GRID_W - 1)) ||
                   (new_y == 6'd0) || (new_y == 6'(GRID_H - 1));
`endif
    end

    // The tail cell is vacated on a plain step, so it only counts when the snake grows.
    always_comb begin
        live_mask = '0;
        self_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            live_mask[i] = (i < int'(len_q));
            self_mask[i] = (i >= 1) && (grow_now ? (i < int'(len_q)) : (i < int'(len_q) - 1));
        end
    end

    assign self_hit = |(new_match & self_mask);
    assign collide  = tick && (wall_hit || self_hit);
    assign shift    = tick && !(wall_hit || self_hit);
    assign load     = (state_q == S_DEAD) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_RIGHT;
            next_dir_q  <= DIR_RIGHT;
            cnt_q       <= '0;
            len_q       <= 6'(RST_LEN);
            grow_pend_q <= 1'b0;
            add_q       <= 1'b0;
            q_hit_q     <= 1'b0;
        end else begin
            add_q   <= addLength;
            q_hit_q <= |(q_match & live_mask);
            if (btn_valid && !is_reverse(btn_dir, ref_dir)) next_dir_q <= btn_dir;
            case (state_q)
                S_IDLE: if (start) state_q <= S_RUN;
                S_RUN: begin
                    cnt_q <= tick ? '0 : cnt_q + 1'b1;
                    if (add_rise) grow_pend_q <= 1'b1;
                    if (tick) begin
                        grow_pend_q <= 1'b0;
                        if (collide) begin
                            state_q <= S_DEAD;
                        end else begin
                            dir_q <= next_dir_q;
                            if (grow_now) len_q <= len_q + 6'd1;
                        end
                    end
                end
                S_DEAD: if (start) begin
                    state_q     <= S_IDLE;
                    dir_q       <= DIR_RIGHT;
                    next_dir_q  <= DIR_RIGHT;
                    cnt_q       <= '0;
                    len_q       <= 6'(RST_LEN);
                    grow_pend_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    snake_seg_array #(.MAX_LEN(MAX_LEN)) u_segs (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .shift_i     (shift),
        .new_head_i  ({new_x, new_y}),
        .qx_i        (qX),
        .qy_i        (qY),
        .head_o      (head_seg),
        .new_match_o (new_match),
        .q_match_o   (q_match)
    );

    assign headX    = head_seg[11:6];
    assign headY    = head_seg[5:0];
    assign length   = len_q;
    assign qHit     = q_hit_q;
    assign gameOver = (state_q == S_DEAD);
    assign running  = (state_q == S_RUN);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb/tb_snake_body_ctrl.sv - scoreboard bench for snake_body_ctrl (MOVE_DIV=4, second instance MAX_LEN=4)
module tb_snake_body_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, addLength;
    logic [3:0] dirBtn;
    logic [5:0] qX, qY;
    logic [5:0] headX, headY, length, headX4, headY4, length4;
    logic       qHit, gameOver, running, qHit4, gameOver4, running4;

    localparam logic [3:0] BTN_UP = 4'b1000, BTN_DOWN = 4'b0100, BTN_LEFT = 4'b0010;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    snake_body_ctrl #(.MOVE_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dirBtn(dirBtn), .addLength(addLength),
        .qX(qX), .qY(qY), .headX(headX), .headY(headY), .length(length),
        .qHit(qHit), .gameOver(gameOver), .running(running)
    );

    snake_body_ctrl #(.MOVE_DIV(4), .MAX_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .dirBtn(dirBtn), .addLength(addLength),
        .qX(qX), .qY(qY), .headX(headX4), .headY(headY4), .length(length4),
        .qHit(qHit4), .gameOver(gameOver4), .running(running4)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        start = 0; addLength = 0; dirBtn = 0; qX = 0; qY = 0; rst = 1;
        cyc(2);
        rst = 0;
        cyc(1);
    endtask

    task automatic pulse_start;
        start = 1; cyc(1); start = 0;
    endtask

    task automatic query(input int x, input int y);
        qX = 6'(x); qY = 6'(y); cyc(1);
    endtask

    task automatic steer(input logic [3:0] b);
        dirBtn = b; cyc(1); dirBtn = 0; cyc(3);
    endtask

    task automatic test_reset;
        apply_reset();
        sb.push_back('{"rst_headX", 20}); sb.push_back('{"rst_headY", 15}); sb.push_back('{"rst_len", 3});
        sb.push_back('{"rst_running", 0}); sb.push_back('{"rst_gameOver", 0}); sb.push_back('{"rst_qHit", 0});
        e = sb.pop_front(); checks++; if (headX !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, headX, e.val); else passed++;
        e = sb.pop_front(); checks++; if (headY !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, headY, e.val); else passed++;
        e = sb.pop_front(); checks++; if (length !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, length, e.val); else passed++;
        e = sb.pop_front(); checks++; if (running !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, running, e.val); else passed++;
        e = sb.pop_front(); checks++; if (gameOver !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, gameOver, e.val); else passed++;
        e = sb.pop_front(); checks++; if (qHit !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, qHit, e.val); else passed++;
    endtask

    task automatic test_run_straight;
        apply_reset();
        pulse_start();
        sb.push_back('{"run_running", 1});
        e = sb.pop_front(); checks++; if (running !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, running, e.val); else passed++;
        for (int k = 0; k < 3; k++) sb.push_back('{$sformatf("run_headX_%0d", k), 21 + k});
        for (int k = 0; k < 3; k++) begin
            cyc(4);
            e = sb.pop_front(); checks++; if (headX !== 6'(e.val) || headY !== 6'd15) $display("FAIL %s got (%0d,%0d) want (%0d,15)", e.name, headX, headY, e.val); else passed++;
        end
        sb.push_back('{"run_len", 3}); sb.push_back('{"run_body_22", 1}); sb.push_back('{"run_vacated_20", 0});
        e = sb.pop_front(); checks++; if (length !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, length, e.val); else passed++;
        query(22, 15);
        e = sb.pop_front(); checks++; if (qHit !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, qHit, e.val); else passed++;
        query(20, 15);
        e = sb.pop_front(); checks++; if (qHit !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, qHit, e.val); else passed++;
    endtask

    task automatic test_direction;
        apply_reset();
        pulse_start();
        sb.push_back('{"dir_step1_y", 16}); sb.push_back('{"dir_step2_y", 17});
        dirBtn = BTN_LEFT; cyc(1); dirBtn = BTN_DOWN; cyc(1); dirBtn = 0; cyc(2);
        e = sb.pop_front(); checks++; if (headX !== 6'd20 || headY !== 6'(e.val)) $display("FAIL %s got (%0d,%0d) want (20,%0d)", e.name, headX, headY, e.val); else passed++;
        cyc(4);
        e = sb.pop_front(); checks++; if (headX !== 6'd20 || headY !== 6'(e.val)) $display("FAIL %s got (%0d,%0d) want (20,%0d)", e.name, headX, headY, e.val); else passed++;
    endtask

    task automatic test_grow_held;
        apply_reset();
        pulse_start();
        sb.push_back('{"grow_len_first", 4}); sb.push_back('{"grow_old_tail", 1});
        sb.push_back('{"grow_len_held", 4}); sb.push_back('{"grow_headX", 25});
        addLength = 1;
        cyc(4);
        e = sb.pop_front(); checks++; if (length !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, length, e.val); else passed++;
        query(18, 15);
        e = sb.pop_front(); checks++; if (qHit !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, qHit, e.val); else passed++;
        cyc(15);
        addLength = 0;
        e = sb.pop_front(); checks++; if (length !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, length, e.val); else passed++;
        e = sb.pop_front(); checks++; if (headX !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, headX, e.val); else passed++;
    endtask

    task automatic test_wall;
        apply_reset();
        pulse_start();
        sb.push_back('{"wall_before_x", 38});
        cyc(4 * 18);
        e = sb.pop_front(); checks++; if (headX !== 6'(e.val) || gameOver !== 1'b0) $display("FAIL %s got x=%0d go=%0d want x=%0d go=0", e.name, headX, gameOver, e.val); else passed++;
`ifdef SNAKE_WRAP_WALLS_EN
        sb.push_back('{"wrap_x", 1});
        cyc(4);
        e = sb.pop_front(); checks++; if (headX !== 6'(e.val) || gameOver !== 1'b0 || running !== 1'b1) $display("FAIL %s got x=%0d go=%0d run=%0d want x=%0d go=0 run=1", e.name, headX, gameOver, running, e.val); else passed++;
`else
        sb.push_back('{"wall_frozen_x", 38}); sb.push_back('{"wall_gameOver", 1}); sb.push_back('{"wall_len", 3});
        sb.push_back('{"restart_headX", 20}); sb.push_back('{"restart_state", 0});
        cyc(4);
        e = sb.pop_front(); checks++; if (headX !== 6'(e.val) || headY !== 6'd15) $display("FAIL %s got (%0d,%0d) want (%0d,15)", e.name, headX, headY, e.val); else passed++;
        e = sb.pop_front(); checks++; if (gameOver !== 1'(e.val) || running !== 1'b0) $display("FAIL %s got go=%0d run=%0d want go=%0d run=0", e.name, gameOver, running, e.val); else passed++;
        e = sb.pop_front(); checks++; if (length !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, length, e.val); else passed++;
        pulse_start();
        e = sb.pop_front(); checks++; if (headX !== 6'(e.val) || headY !== 6'd15 || length !== 6'd3) $display("FAIL %s got (%0d,%0d) len %0d want (%0d,15) len 3", e.name, headX, headY, length, e.val); else passed++;
        e = sb.pop_front(); checks++; if (gameOver !== 1'(e.val) || running !== 1'(e.val)) $display("FAIL %s got go=%0d run=%0d want both %0d", e.name, gameOver, running, e.val); else passed++;
`endif
    endtask

    task automatic test_self_hit;
        apply_reset();
        pulse_start();
        sb.push_back('{"self_len5", 5}); sb.push_back('{"self_gameOver", 1}); sb.push_back('{"self_frozen_y", 14});
        for (int k = 0; k < 2; k++) begin
            addLength = 1; cyc(1); addLength = 0; cyc(3);
        end
        e = sb.pop_front(); checks++; if (length !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, length, e.val); else passed++;
        steer(BTN_UP); steer(BTN_LEFT); steer(BTN_DOWN);
        e = sb.pop_front(); checks++; if (gameOver !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, gameOver, e.val); else passed++;
        e = sb.pop_front(); checks++; if (headX !== 6'd21 || headY !== 6'(e.val) || length !== 6'd5) $display("FAIL %s got (%0d,%0d) len %0d want (21,%0d) len 5", e.name, headX, headY, length, e.val); else passed++;
        apply_reset();
        pulse_start();
        sb.push_back('{"chase_alive", 0}); sb.push_back('{"chase_head_y", 15});
        addLength = 1; cyc(1); addLength = 0; cyc(3);
        steer(BTN_UP); steer(BTN_LEFT); steer(BTN_DOWN);
        e = sb.pop_front(); checks++; if (gameOver !== 1'(e.val) || running !== 1'b1) $display("FAIL %s got go=%0d run=%0d want go=%0d run=1", e.name, gameOver, running, e.val); else passed++;
        e = sb.pop_front(); checks++; if (headX !== 6'd20 || headY !== 6'(e.val) || length !== 6'd4) $display("FAIL %s got (%0d,%0d) len %0d want (20,%0d) len 4", e.name, headX, headY, length, e.val); else passed++;
    endtask

    task automatic test_max_len;
        apply_reset();
        sb.push_back('{"q_seg2", 1}); sb.push_back('{"q_seg2_max4", 1}); sb.push_back('{"q_unused00", 0});
        sb.push_back('{"q_past_tail", 0}); sb.push_back('{"max4_len", 4}); sb.push_back('{"max32_len", 6});
        query(18, 15);
        e = sb.pop_front(); checks++; if (qHit !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, qHit, e.val); else passed++;
        e = sb.pop_front(); checks++; if (qHit4 !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, qHit4, e.val); else passed++;
        query(0, 0);
        e = sb.pop_front(); checks++; if (qHit !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, qHit, e.val); else passed++;
        query(17, 15);
        e = sb.pop_front(); checks++; if (qHit !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, qHit, e.val); else passed++;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            addLength = 1; cyc(1); addLength = 0; cyc(3);
        end
        e = sb.pop_front(); checks++; if (length4 !== 6'(e.val) || headX4 !== 6'd23 || running4 !== 1'b1) $display("FAIL %s got len %0d x %0d run %0d want len %0d x 23 run 1", e.name, length4, headX4, running4, e.val); else passed++;
        e = sb.pop_front(); checks++; if (length !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, length, e.val); else passed++;
    endtask

    task automatic test_back_to_back;
        apply_reset();
        pulse_start();
        sb.push_back('{"tick_edge_len", 4}); sb.push_back('{"tick_start_running", 1}); sb.push_back('{"tick_edge_once", 4});
        cyc(3);
        addLength = 1; start = 1;
        cyc(1);
        start = 0;
        e = sb.pop_front(); checks++; if (length !== 6'(e.val) || headX !== 6'd21) $display("FAIL %s got len %0d x %0d want len %0d x 21", e.name, length, headX, e.val); else passed++;
        e = sb.pop_front(); checks++; if (running !== 1'(e.val)) $display("FAIL %s got %0d want %0d", e.name, running, e.val); else passed++;
        cyc(4);
        addLength = 0;
        e = sb.pop_front(); checks++; if (length !== 6'(e.val)) $display("FAIL %s got %0d want %0d", e.name, length, e.val); else passed++;
    endtask

    initial begin
        test_reset();
        test_run_straight();
        test_direction();
        test_grow_held();
        test_wall();
        test_self_hit();
        test_max_len();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
